knn_topk_vote: RTL and testbench

//  Parametrised successor to the fixed 5-neighbour sort / K3-K5 vote / latency path of the KNN top.

---
 rtl/knn_topk_vote.sv | 163 ++++++++++++++++
 tb/tb_knn_topk_vote.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_vote.sv
// Streaming K-nearest-neighbour selector: keeps the K_MAX closest (distance, class) samples
// sorted on the fly, then votes one class per cycle over the first K slots.
module knn_topk_vote #(
   parameter int DIST_W  = 17,
   parameter int CLASS_W = 1,
   parameter int K_MAX   = 7,
   parameter int LAT_W   = 16,
   localparam int KW          = $clog2(K_MAX + 1),
   localparam int NUM_CLASSES = 2 ** CLASS_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [KW-1:0]      k_sel,
   input  logic               in_valid,
   input  logic [DIST_W-1:0]  in_dist,
   input  logic [CLASS_W-1:0] in_class,
   input  logic               in_last,
   output logic               in_ready,
   output logic               busy,
   output logic               result_valid,
   output logic [CLASS_W-1:0] predicted_class,
   output logic [KW-1:0]      vote_count,
   output logic [LAT_W-1:0]   latency,
   output logic               err_k
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      VOTE,
      DONE
   } state_t;

   localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

   state_t state, next_state;

   logic [DIST_W-1:0]  slot_dist [K_MAX];
   logic [CLASS_W-1:0] slot_cls  [K_MAX];
   logic               slot_vld  [K_MAX];

   logic [DIST_W-1:0]  nxt_dist  [K_MAX];
   logic [CLASS_W-1:0] nxt_cls   [K_MAX];
   logic               nxt_vld   [K_MAX];
   logic               le        [K_MAX];

   logic [KW-1:0]      k_reg;
   logic [CLASS_W-1:0] vote_idx;
   logic [KW-1:0]      class_count;

   logic start_acc;
   logic sample_acc;
   logic k_bad;

   assign start_acc  = start && (state == IDLE || state == DONE);
   assign sample_acc = in_valid && (state == COLLECT);
   assign k_bad      = (k_sel == '0) || ({1'b0, k_sel} > (KW + 1)'(K_MAX));

   assign in_ready     = (state == COLLECT);
   assign busy         = (state == COLLECT) || (state == VOTE);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = COLLECT;
         COLLECT: if (in_valid && in_last) next_state = VOTE;
         VOTE:    if (vote_idx == LAST_CLASS) next_state = DONE;
         DONE:    if (start) next_state = COLLECT;
         default: next_state = IDLE;
      endcase
   end

   // le[] is a prefix mask because valid slots stay packed and sorted; the new sample
   // lands at the first slot that is not <= it, and everything behind shifts down one.
   always_comb begin
      for (int i = 0; i < K_MAX; i++) begin
         le[i] = slot_vld[i] && (slot_dist[i] <= in_dist);
      end
      nxt_dist[0] = le[0] ? slot_dist[0] : in_dist;
      nxt_cls[0]  = le[0] ? slot_cls[0]  : in_class;
      nxt_vld[0]  = 1'b1;
      for (int i = 1; i < K_MAX; i++) begin
         if (le[i]) begin
            nxt_dist[i] = slot_dist[i];
            nxt_cls[i]  = slot_cls[i];
            nxt_vld[i]  = slot_vld[i];
         end else if (le[i-1]) begin
            nxt_dist[i] = in_dist;
            nxt_cls[i]  = in_class;
            nxt_vld[i]  = 1'b1;
         end else begin
            nxt_dist[i] = slot_dist[i-1];
            nxt_cls[i]  = slot_cls[i-1];
            nxt_vld[i]  = slot_vld[i-1];
         end
      end
   end

   always_comb begin
      class_count = '0;
      for (int i = 0; i < K_MAX; i++) begin
         if (slot_vld[i] && (KW'(i) < k_reg) && (slot_cls[i] == vote_idx)) begin
            class_count = class_count + KW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < K_MAX; i++) begin
            slot_dist[i] <= '0;
            slot_cls[i]  <= '0;
            slot_vld[i]  <= 1'b0;
         end
         k_reg           <= '0;
         err_k           <= 1'b0;
         latency         <= '0;
         predicted_class <= '0;
         vote_count      <= '0;
         vote_idx        <= '0;
      end else if (start_acc) begin
         for (int i = 0; i < K_MAX; i++) begin
            slot_vld[i] <= 1'b0;
         end
         k_reg           <= k_bad ? KW'(K_MAX) : k_sel;
         err_k           <= k_bad;
         latency         <= '0;
         predicted_class <= '0;
         vote_count      <= '0;
         vote_idx        <= '0;
      end else begin
         if (busy && (latency != '1)) begin
            latency <= latency + LAT_W'(1);
         end
         if (sample_acc) begin
            for (int i = 0; i < K_MAX; i++) begin
               slot_dist[i] <= nxt_dist[i];
               slot_cls[i]  <= nxt_cls[i];
               slot_vld[i]  <= nxt_vld[i];
            end
         end
         // Strictly-greater replacement keeps the lowest class index on ties.
         if (state == VOTE) begin
            if (class_count > vote_count) begin
               vote_count      <= class_count;
               predicted_class <= vote_idx;
            end
            vote_idx <= vote_idx + CLASS_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Randomised and directed bench for knn_topk_vote, checked every cycle against a
// transaction-level model that re-sorts all received samples when the dataset ends.
module tb_knn_topk_vote;

   localparam int DIST_W      = 17;
   localparam int CLASS_W     = 1;
   localparam int K_MAX       = 7;
   localparam int LAT_W       = 16;
   localparam int KW          = $clog2(K_MAX + 1);
   localparam int NUM_CLASSES = 2 ** CLASS_W;
   localparam int LAT_MAX     = (1 << LAT_W) - 1;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [KW-1:0]      k_sel = '0;
   logic               in_valid = 1'b0;
   logic [DIST_W-1:0]  in_dist = '0;
   logic [CLASS_W-1:0] in_class = '0;
   logic               in_last = 1'b0;
   logic               in_ready;
   logic               busy;
   logic               result_valid;
   logic [CLASS_W-1:0] predicted_class;
   logic [KW-1:0]      vote_count;
   logic [LAT_W-1:0]   latency;
   logic               err_k;

   int checks = 0;
   int errors = 0;

   int sd [16];
   int sc [16];

   // Model state: samples seen this dataset, collect/vote progress and expected results.
   bit m_collect = 0;
   int m_vote_left = 0;
   bit m_result = 0;
   bit m_fresh = 1;
   bit m_err = 0;
   int m_k = 0;
   int m_lat = 0;
   int m_pred = 0;
   int m_votes = 0;
   int m_q_d [$];
   int m_q_c [$];

   knn_topk_vote #(
      .DIST_W (DIST_W),
      .CLASS_W(CLASS_W),
      .K_MAX  (K_MAX),
      .LAT_W  (LAT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .k_sel          (k_sel),
      .in_valid       (in_valid),
      .in_dist        (in_dist),
      .in_class       (in_class),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .busy           (busy),
      .result_valid   (result_valid),
      .predicted_class(predicted_class),
      .vote_count     (vote_count),
      .latency        (latency),
      .err_k          (err_k)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Nearest-K by repeated minimum search over every received sample (earliest wins ties).
   function automatic void predict();
      int kk;
      int best;
      int cnt [NUM_CLASSES];
      bit used [$];
      for (int c = 0; c < NUM_CLASSES; c++) cnt[c] = 0;
      for (int i = 0; i < m_q_d.size(); i++) used.push_back(1'b0);
      kk = (m_k < m_q_d.size()) ? m_k : m_q_d.size();
      for (int j = 0; j < kk; j++) begin
         best = -1;
         for (int i = 0; i < m_q_d.size(); i++) begin
            if (!used[i] && (best < 0 || m_q_d[i] < m_q_d[best])) best = i;
         end
         used[best] = 1'b1;
         cnt[m_q_c[best]]++;
      end
      m_pred  = 0;
      m_votes = cnt[0];
      for (int c = 1; c < NUM_CLASSES; c++) begin
         if (cnt[c] > m_votes) begin
            m_pred  = c;
            m_votes = cnt[c];
         end
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_collect = 0; m_vote_left = 0; m_result = 0; m_fresh = 1;
            m_err = 0; m_lat = 0; m_pred = 0; m_votes = 0;
            m_q_d.delete(); m_q_c.delete();
         end else if (start && !m_collect && m_vote_left == 0) begin
            m_collect = 1; m_result = 0; m_fresh = 0; m_lat = 0;
            m_q_d.delete(); m_q_c.delete();
            if (k_sel == 0 || int'(k_sel) > K_MAX) begin
               m_k = K_MAX; m_err = 1;
            end else begin
               m_k = int'(k_sel); m_err = 0;
            end
         end else if (m_collect) begin
            if (m_lat < LAT_MAX) m_lat++;
            if (in_valid) begin
               m_q_d.push_back(int'(in_dist));
               m_q_c.push_back(int'(in_class));
               if (in_last) begin
                  m_collect = 0;
                  m_vote_left = NUM_CLASSES;
                  predict();
               end
            end
         end else if (m_vote_left > 0) begin
            if (m_lat < LAT_MAX) m_lat++;
            m_vote_left--;
            if (m_vote_left == 0) m_result = 1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         checkOutput("in_ready", in_ready, m_collect);
         checkOutput("busy", busy, (m_collect || m_vote_left > 0));
         checkOutput("result_valid", result_valid, m_result);
         checkOutput("latency", latency, m_lat);
         checkOutput("err_k", err_k, m_err);
         if (m_result || m_fresh) begin
            checkOutput("predicted_class", predicted_class, m_pred);
            checkOutput("vote_count", vote_count, m_votes);
         end
      end
   end

   task automatic applyStimulus(input int k, input int n, input int gap_at, input int gap_len,
                                input int pulse_at, input bit rnd);
      start = 1'b1;
      k_sel = KW'(k);
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid = 1'b0;
               step();
            end
         end
         if (rnd && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'(($urandom_range(0, 1)));
            in_dist  = DIST_W'($urandom_range(0, 15));
            step();
         end
         start    = (i == pulse_at);
         k_sel    = (i == pulse_at) ? KW'(1) : k_sel;
         in_valid = 1'b1;
         in_dist  = DIST_W'(sd[i]);
         in_class = CLASS_W'(sc[i]);
         in_last  = (i == n - 1);
         step();
         start = 1'b0;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int w = 0; w < 40 && result_valid !== 1'b1; w++) step();
      checkOutput("result_wait", result_valid, 1);
   endtask

   task automatic load_stream1();
      sd[0] = 10; sc[0] = 1;
      sd[1] = 5;  sc[1] = 0;
      sd[2] = 20; sc[2] = 1;
      sd[3] = 7;  sc[3] = 1;
      sd[4] = 3;  sc[4] = 0;
   endtask

   task automatic pin(input string name, input int pred, input int votes, input int lat, input int errk);
      checkOutput({name, "_pred"}, predicted_class, pred);
      checkOutput({name, "_votes"}, vote_count, votes);
      checkOutput({name, "_lat"}, latency, lat);
      checkOutput({name, "_errk"}, err_k, errk);
      checkOutput({name, "_model_pred"}, m_pred, pred);
      checkOutput({name, "_model_votes"}, m_votes, votes);
      checkOutput({name, "_model_lat"}, m_lat, lat);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) step();
      checkOutput("reset_ready", in_ready, 0);
      checkOutput("reset_valid", result_valid, 0);
      checkOutput("reset_lat", latency, 0);
      reset = 1'b0;
      step();

      load_stream1();
      applyStimulus(3, 5, -1, 0, -1, 0);
      pin("k3", 0, 2, 7, 0);

      applyStimulus(5, 5, -1, 0, -1, 0);
      pin("k5", 1, 3, 7, 0);

      sd[0] = 8; sc[0] = 1;
      sd[1] = 8; sc[1] = 0;
      applyStimulus(1, 2, -1, 0, -1, 0);
      pin("tie", 1, 1, 4, 0);

      sd[0] = 4; sc[0] = 0;
      sd[1] = 9; sc[1] = 1;
      applyStimulus(0, 2, -1, 0, -1, 0);
      pin("k0", 0, 1, 4, 1);

      sd[0] = 6; sc[0] = 0;
      sd[1] = 2; sc[1] = 1;
      sd[2] = 9; sc[2] = 1;
      applyStimulus(3, 3, 1, 3, -1, 0);
      pin("gap", 1, 2, 8, 0);

      start = 1'b1; k_sel = 3;
      step();
      start = 1'b0;
      in_valid = 1'b1; in_dist = 6; in_class = 0; in_last = 1'b0;
      step();
      in_dist = 2; in_class = 1;
      step();
      in_valid = 1'b0;
      reset = 1'b1;
      step();
      checkOutput("midrst_ready", in_ready, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_valid", result_valid, 0);
      reset = 1'b0;
      step();
      load_stream1();
      applyStimulus(3, 5, -1, 0, -1, 0);
      pin("after_rst", 0, 2, 7, 0);

      applyStimulus(5, 5, -1, 0, 2, 0);
      pin("pulse", 1, 3, 7, 0);

      start = 1'b1; k_sel = 3;
      step();
      start = 1'b0;
      checkOutput("restart_valid", result_valid, 0);
      checkOutput("restart_ready", in_ready, 1);
      checkOutput("restart_lat", latency, 0);
      in_valid = 1'b1; in_dist = 1; in_class = 1; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int w = 0; w < 40 && result_valid !== 1'b1; w++) step();
      pin("restart", 1, 1, 3, 0);

      for (int t = 0; t < 40; t++) begin
         int n;
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            sd[i] = $urandom_range(0, 15);
            sc[i] = $urandom_range(0, 1);
         end
         if (t % 10 == 9) begin
            start = 1'b1; k_sel = KW'($urandom_range(0, 7));
            step();
            start = 1'b0;
            in_valid = 1'b1; in_dist = DIST_W'(sd[0]); in_class = CLASS_W'(sc[0]);
            step();
            in_valid = 1'b0;
            reset = 1'b1;
            step();
            reset = 1'b0;
            step();
         end
         applyStimulus($urandom_range(0, 7), n, -1, 0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1, 1);
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'(($urandom_range(0, 1)));
            in_last  = 1'(($urandom_range(0, 1)));
            step();
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
      end

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
